branch_predictor: RTL and testbench

Gshare-style branch predictor with a direct-mapped branch target buffer (BTB), sitting in the IF stage directly upstream of hazard detection. Each cycle it predicts the next fetch PC from the current fetch PC. Its `prediction` bit travels down the pipeline to be compared against the resolved outcome. The block trains non-speculatively from the resolved control-flow instruction in EX.

---
 rtl/branch_predictor.sv | 67 ++++++
 tb/tb_branch_predictor.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: gshare direction predictor with a direct-mapped BTB, trained from resolved EX outcomes
module branch_predictor #(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IF_pc,
  output logic             prediction,
  output logic [31:0]      predicted_pc,
  output logic [IDX_W-1:0] IF_pht_index,
  input  logic             EX_update,
  input  logic [31:0]      EX_pc,
  input  logic [IDX_W-1:0] EX_pht_index,
  input  logic             EX_taken,
  input  logic [31:0]      EX_target
);
  localparam int N = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;
  logic [N-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [N];
  logic [TAG_W-1:0]   tag_d [N];
  logic [31:0]        target_q [N];
  logic [31:0]        target_d [N];
  logic [1:0]         pht_q [N];
  logic [1:0]         pht_d [N];
  logic [IDX_W-1:0]   bhr_q, bhr_d;
  logic [IDX_W-1:0]   if_idx, ex_idx;
  logic [1:0]         ex_ctr;
  logic               hit;
  assign if_idx       = IF_pc[IDX_W+1:2];
  assign ex_idx       = EX_pc[IDX_W+1:2];
  assign ex_ctr       = pht_q[EX_pht_index];
  assign hit          = valid_q[if_idx] && tag_q[if_idx] == IF_pc[31:IDX_W+2];
  assign IF_pht_index = if_idx ^ bhr_q;
  assign prediction   = hit && pht_q[IF_pht_index][1];
  assign predicted_pc = prediction ? target_q[if_idx] : IF_pc + 32'd4;
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    pht_d    = pht_q;
    bhr_d    = bhr_q;
    if (EX_update) begin
      pht_d[EX_pht_index] = EX_taken ? (ex_ctr == 2'b11 ? 2'b11 : ex_ctr + 2'd1)
                                     : (ex_ctr == 2'b00 ? 2'b00 : ex_ctr - 2'd1);
      bhr_d = {bhr_q[IDX_W-2:0], EX_taken};
      if (EX_taken) begin
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = EX_pc[31:IDX_W+2];
        target_d[ex_idx] = EX_target;
      end
    end
  end
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
    if (reset) begin
      valid_q <= '0;
      bhr_q   <= '0;
      pht_q   <= '{default: 2'b01};
    end else begin
      valid_q <= valid_d;
      bhr_q   <= bhr_d;
      pht_q   <= pht_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed test-plan checks plus randomized traffic against a behavioural predictor model
module tb_branch_predictor;
  localparam int W = 5;
  localparam int N = 1 << W;
  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  IF_pc;
  logic         prediction;
  logic [31:0]  predicted_pc;
  logic [W-1:0] IF_pht_index;
  logic         EX_update;
  logic [31:0]  EX_pc;
  logic [W-1:0] EX_pht_index;
  logic         EX_taken;
  logic [31:0]  EX_target;
  always #5 clk = ~clk;
  branch_predictor #(.IDX_W(W)) dut (
    .clk(clk), .reset(reset), .IF_pc(IF_pc), .prediction(prediction),
    .predicted_pc(predicted_pc), .IF_pht_index(IF_pht_index), .EX_update(EX_update),
    .EX_pc(EX_pc), .EX_pht_index(EX_pht_index), .EX_taken(EX_taken), .EX_target(EX_target)
  );
  // model: each slot remembers the full PC last trained taken into it; counters are plain ints
  bit          m_valid [N];
  logic [31:0] m_pc [N];
  logic [31:0] m_tgt [N];
  int          m_ctr [N];
  int          m_hist;
  bit          ready = 1'b0;
  int          nvec = 0;
  int          nerr = 0;
  int          mj, mk;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
      m_hist = 0;
      ready  = 1'b1;
    end else if (EX_update) begin
      mj = int'(EX_pht_index);
      m_ctr[mj] = EX_taken ? (m_ctr[mj] >= 3 ? 3 : m_ctr[mj] + 1) : (m_ctr[mj] <= 0 ? 0 : m_ctr[mj] - 1);
      m_hist = (m_hist * 2 + (EX_taken ? 1 : 0)) % N;
      if (EX_taken) begin
        mk = int'((EX_pc >> 2) % 32'(N));
        m_valid[mk] = 1'b1;
        m_pc[mk]    = EX_pc;
        m_tgt[mk]   = EX_target;
      end
    end
  end
  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % 32'(N));
  endfunction
  function automatic int e_idx(input logic [31:0] pc);
    return slot(pc) ^ m_hist;
  endfunction
  function automatic bit e_pred(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_pc[slot(pc)] >> 2) == (pc >> 2) && m_ctr[e_idx(pc)] >= 2;
  endfunction
  function automatic logic [31:0] e_npc(input logic [31:0] pc);
    return e_pred(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (ready) begin
      chk("model_pred", 32'(prediction), 32'(e_pred(IF_pc)));
      chk("model_npc", predicted_pc, e_npc(IF_pc));
      chk("model_idx", 32'(IF_pht_index), 32'(e_idx(IF_pc)));
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic look(input string nm, input logic [31:0] pc, input bit p, input logic [31:0] npc, input int ix);
    IF_pc = pc;
    #1;
    chk({nm, "_pred"}, 32'(prediction), 32'(p));
    chk({nm, "_npc"}, predicted_pc, npc);
    chk({nm, "_idx"}, 32'(IF_pht_index), 32'(ix));
  endtask
  task automatic upd(input logic [31:0] pc, input int ix, input bit tk, input logic [31:0] tg);
    EX_update    = 1'b1;
    EX_pc        = pc;
    EX_pht_index = W'(ix);
    EX_taken     = tk;
    EX_target    = tg;
    tick();
    EX_update    = 1'b0;
  endtask
  task automatic set_hist(input logic [W-1:0] h);
    for (int b = W - 1; b >= 0; b--) upd(32'h1000, h[b] ? 1 : 0, h[b], 32'h2000);
  endtask
  function automatic logic [31:0] rpc();
    if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, N - 1)) << 2);
  endfunction
  initial begin
    reset = 1'b1; IF_pc = 32'h100; EX_update = 1'b1; EX_taken = 1'b1;
    EX_pc = 32'h100; EX_target = 32'h999; EX_pht_index = '0;
    tick();
    reset = 1'b0; EX_update = 1'b0;
    look("reset", 32'h100, 0, 32'h104, 0);
    upd(32'h40, 'h10, 1, 32'h80);
    look("train1", 32'h40, 0, 32'h44, 'h11);
    upd(32'h40, 'h11, 1, 32'h80);
    look("train2", 32'h40, 0, 32'h44, 'h13);
    upd(32'h40, 'h13, 1, 32'h80);
    upd(32'h40, 'h13, 1, 32'h80);
    set_hist(5'h03);
    look("train3", 32'h40, 1, 32'h80, 'h13);
    chk("model_ctr13", 32'(m_ctr['h13]), 32'd3);
    repeat (4) upd(32'h40, 5, 1, 32'h80);
    set_hist(5'h15);
    look("sat11", 32'h40, 1, 32'h80, 5);
    upd(32'h40, 5, 0, 32'h0);
    set_hist(5'h15);
    look("sat10", 32'h40, 1, 32'h80, 5);
    repeat (3) upd(32'h40, 5, 0, 32'h0);
    set_hist(5'h15);
    look("sat00", 32'h40, 0, 32'h44, 5);
    chk("model_ctr5", 32'(m_ctr[5]), 32'd0);
    upd(32'h40, 2, 1, 32'h200);
    upd(32'hC0, 3, 1, 32'h300);
    set_hist(5'h03);
    look("alias_old", 32'h40, 0, 32'h44, 'h13);
    look("alias_new", 32'hC0, 1, 32'h300, 'h13);
    EX_update = 1'b1; EX_taken = 1'b1; EX_pc = 32'hC0; EX_pht_index = W'('h13); EX_target = 32'h400;
    reset = 1'b1;
    tick();
    reset = 1'b0; EX_update = 1'b0;
    look("rst_upd", 32'hC0, 0, 32'hC4, 'h10);
    set_hist(5'h03);
    look("rst_inval", 32'hC0, 0, 32'hC4, 'h13);
    upd(32'h40, 'h17, 1, 32'h80);
    look("rst_pht", 32'h40, 1, 32'h80, 'h17);
    look("wrap", 32'hFFFF_FFFC, 0, 32'h0, 'h18);
    IF_pc = 32'h40;
    for (int c = 0; c < 10; c++) begin
      EX_pc = $urandom; EX_target = $urandom; EX_taken = 1'($urandom); EX_pht_index = W'($urandom);
      tick();
      look("bubble", 32'h40, 1, 32'h80, 'h17);
    end
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(0, 199) == 0);
      EX_update    = ($urandom_range(0, 9) < 7);
      EX_pc        = rpc();
      EX_pht_index = W'($urandom);
      EX_taken     = 1'($urandom);
      EX_target    = $urandom & 32'hFFFF_FFFC;
      IF_pc        = rpc();
      tick();
    end
    reset = 1'b0; EX_update = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
